// File: rtl/ddr_txn_sched_pkg.sv
// Shared types and helpers for the DDR transaction scheduler and its arbiter.
package ddr_txn_sched_pkg;

    localparam int unsigned ERR_CNT_W = 16;
    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned PICK_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        INIT,
        WAIT,
        DONE
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [PICK_W-1:0] idx;
    } rr_pick_t;

    // First set request at or after ptr, wrapping modulo num_req.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [PICK_W-1:0]  ptr,
        input int unsigned        num_req
    );
        rr_pick_t    res;
        int unsigned pos;
        res = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = k + 32'(ptr);
            if (pos >= num_req) begin
                pos = pos - num_req;
            end
            if ((k < num_req) && !res.valid && req[pos[PICK_W-1:0]]) begin
                res.valid = 1'b1;
                res.idx   = pos[PICK_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ddr_txn_scheduler_rr_arbiter.sv
// Combinational round-robin pick; reusable for any shared-master scheduler.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);
    import ddr_txn_sched_pkg::*;

    rr_pick_t pick;

    always_comb begin
        pick   = rr_pick(MAX_REQ'(req), PICK_W'(ptr), NUM_REQ);
        valid  = pick.valid;
        idx    = IDX_W'(pick.idx);
        onehot = '0;
        if (pick.valid) begin
            onehot = NUM_REQ'(MAX_REQ'(1) << pick.idx);
        end
    end

endmodule

// File: rtl/ddr_txn_scheduler.sv
// Time-shares one PL_DDR_RW AXI master between NUM_REQ requesters with
// round-robin arbitration, done-edge detection and a completion timeout.
module ddr_txn_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      ack_err,
    output logic                      busy,
    output logic [ADDR_W-1:0]         txn_addr,
    output logic [LEN_W-1:0]          txn_len,
    output logic                      txn_init,
    input  logic                      txn_done,
    input  logic                      txn_error,
    output logic [15:0]               err_count
);
    import ddr_txn_sched_pkg::*;

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC);

    logic                 rst_meta;
    logic                 rst_n;
    state_t               state;
    state_t               state_nxt;
    logic [NUM_REQ-1:0]   gnt_r;
    logic [IDX_W-1:0]     gnt_idx;
    logic [IDX_W-1:0]     rr_ptr;
    logic [TO_W-1:0]      tcnt;
    logic                 done_prev;
    logic                 done_edge;
    logic                 timeout;
    logic                 arb_valid;
    logic [NUM_REQ-1:0]   arb_onehot;
    logic [IDX_W-1:0]     arb_idx;
    logic [ERR_CNT_W-1:0] err_cnt_r;
    logic [ADDR_W-1:0]    addr_arr [NUM_REQ];
    logic [LEN_W-1:0]     len_arr  [NUM_REQ];

    // Reset asserts asynchronously, releases two clocks after ARESETN rises.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign len_arr[i]  = req_len[i*LEN_W +: LEN_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req    (req),
        .ptr    (rr_ptr),
        .valid  (arb_valid),
        .onehot (arb_onehot),
        .idx    (arb_idx)
    );

    assign done_edge = txn_done & ~done_prev;
    assign timeout   = (tcnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (|req) state_nxt = ARB;
            ARB:  state_nxt = arb_valid ? INIT : IDLE;
            INIT: state_nxt = WAIT;
            WAIT: if (done_edge || timeout) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The timeout counter is zeroed entering INIT so it counts from the init pulse.
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r     <= '0;
            gnt_idx   <= '0;
            rr_ptr    <= '0;
            tcnt      <= '0;
            done_prev <= 1'b0;
            txn_addr  <= '0;
            txn_len   <= '0;
            ack_err   <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (arb_valid) begin
                        gnt_r    <= arb_onehot;
                        gnt_idx  <= arb_idx;
                        txn_addr <= addr_arr[arb_idx];
                        txn_len  <= len_arr[arb_idx];
                        tcnt     <= '0;
                    end
                end
                INIT: begin
                    tcnt      <= tcnt + 1'b1;
                    done_prev <= 1'b1;
                end
                WAIT: begin
                    tcnt      <= tcnt + 1'b1;
                    done_prev <= txn_done;
                    if (done_edge) begin
                        ack_err <= txn_error;
                    end else if (timeout) begin
                        ack_err <= 1'b1;
                    end
                end
                DONE: begin
                    gnt_r   <= '0;
                    ack_err <= 1'b0;
                    if (gnt_idx == IDX_W'(NUM_REQ - 1)) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= gnt_idx + 1'b1;
                    end
                    if (ack_err && (err_cnt_r != '1)) begin
                        err_cnt_r <= err_cnt_r + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign ack       = (state == DONE) ? gnt_r : '0;
    assign busy      = (state != IDLE);
    assign txn_init  = (state == INIT);
    assign err_count = err_cnt_r;

endmodule

// File: tb/tb_ddr_txn_scheduler.sv
// Randomized self-checking bench: a transaction-level model predicts grant,
// init latency, completion cycle, error status and error count.
module tb_ddr_txn_scheduler;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int LW = 8;
    localparam int TO = 16;

    logic              ACLK      = 1'b0;
    logic              ARESETN   = 1'b0;
    logic [NR-1:0]     req       = '0;
    logic [NR*AW-1:0]  req_addr  = '0;
    logic [NR*LW-1:0]  req_len   = '0;
    logic              txn_done  = 1'b0;
    logic              txn_error = 1'b0;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     ack;
    logic              ack_err;
    logic              busy;
    logic [AW-1:0]     txn_addr;
    logic [LW-1:0]     txn_len;
    logic              txn_init;
    logic [15:0]       err_count;

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;
    int m_err = 0;

    ddr_txn_scheduler #(
        .NUM_REQ     (NR),
        .ADDR_W      (AW),
        .LEN_W       (LW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .req       (req),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .gnt       (gnt),
        .ack       (ack),
        .ack_err   (ack_err),
        .busy      (busy),
        .txn_addr  (txn_addr),
        .txn_len   (txn_len),
        .txn_init  (txn_init),
        .txn_done  (txn_done),
        .txn_error (txn_error),
        .err_count (err_count)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick_model(input logic [NR-1:0] rq);
        for (int i = 0; i < NR; i++) begin
            if (rq[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
        end
        return 0;
    endfunction

    // mode: 0 fresh rise, 1 no done (timeout), 2 stale level then fresh rise, 3 rise on the deadline cycle
    task automatic run_txn(input logic [NR-1:0] rq, input int mode, input bit errb,
                           input int exp_lat, input bit fixed);
        logic [AW-1:0] a [NR];
        logic [LW-1:0] l [NR];
        logic          w [21];
        logic [NR-1:0] ackv;
        int            idx, lat, j, m, rise, exp_k, ackk, extra;
        bit            exp_err, prev, errv, got;

        for (int i = 0; i < NR; i++) begin
            a[i] = $urandom;
            l[i] = LW'($urandom_range(1, 255));
        end
        if (fixed) begin
            a[0] = 32'h4000_0000;
            l[0] = 8'd16;
        end
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = a[i];
            req_len[i*LW +: LW]  = l[i];
        end

        for (int k = 0; k < 21; k++) w[k] = 1'b0;
        case (mode)
            0: begin
                rise = $urandom_range(2, 15);
                for (int k = rise; k < 21; k++) w[k] = 1'b1;
            end
            1: ;
            2: begin
                j = $urandom_range(2, 6);
                m = $urandom_range(j + 1, 14);
                for (int k = 0; k < j; k++) w[k] = 1'b1;
                for (int k = m; k < 21; k++) w[k] = 1'b1;
            end
            default: begin
                for (int k = 15; k < 21; k++) w[k] = 1'b1;
            end
        endcase

        // Completion: first 0->1 of done in WAIT (prior level counts as 1), else deadline.
        prev    = 1'b1;
        exp_k   = TO;
        exp_err = 1'b1;
        for (int k = 1; k < TO; k++) begin
            if (w[k] && !prev) begin
                exp_k   = k + 1;
                exp_err = errb;
                break;
            end
            prev = w[k];
        end

        idx = pick_model(rq);
        req = rq;
        lat = 0;
        got = 1'b0;
        for (int n = 1; n <= 12 && !got; n++) begin
            @(negedge ACLK);
            if (txn_init) begin
                got = 1'b1;
                lat = n;
            end
        end
        chk("init_lat", lat, exp_lat);
        if (!got) begin
            req = '0;
            return;
        end
        chk("gnt", gnt, 1 << idx);
        chk("txn_addr", txn_addr, a[idx]);
        chk("txn_len", txn_len, l[idx]);

        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = $urandom;
            req_len[i*LW +: LW]  = LW'($urandom);
        end
        txn_done  = w[0];
        txn_error = errb;

        ackk  = 0;
        ackv  = '0;
        errv  = 1'b0;
        extra = 0;
        for (int k = 1; k <= 20 && ackk == 0; k++) begin
            @(negedge ACLK);
            if (txn_init) extra++;
            if (ack != '0) begin
                ackk = k;
                ackv = ack;
                errv = ack_err;
                chk("addr_hold", txn_addr, a[idx]);
                chk("len_hold", txn_len, l[idx]);
            end else begin
                txn_done = w[k];
            end
        end
        chk("ack_cyc", ackk, exp_k);
        chk("ack_who", ackv, 1 << idx);
        chk("ack_err", errv, exp_err);
        chk("init_once", extra, 0);
        req = '0;

        m_ptr = (idx + 1) % NR;
        if (exp_err && m_err < 65535) m_err++;

        @(negedge ACLK);
        chk("idle_busy", busy, 0);
        chk("idle_gnt", gnt, 0);
        chk("ack_clr", ack, 0);
        chk("err_count", err_count, m_err);
    endtask

    initial begin
        bit got;

        repeat (4) @(negedge ACLK);
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_init", txn_init, 0);
        chk("rst_addr", txn_addr, 0);
        chk("rst_len", txn_len, 0);
        chk("rst_errc", err_count, 0);
        ARESETN = 1'b1;
        repeat (4) @(negedge ACLK);

        run_txn(4'b0001, 0, 1'b0, 2, 1'b1);

        for (int t = 0; t < 6; t++) run_txn(4'b1111, 0, 1'(t == 3), 2, 1'b0);

        run_txn(4'b0100, 0, 1'b1, 2, 1'b0);

        run_txn(4'b1000, 1, 1'b0, 2, 1'b0);
        run_txn(4'b1001, 0, 1'b0, 2, 1'b0);

        run_txn(4'b0010, 0, 1'b0, 2, 1'b0);
        run_txn(4'b0010, 2, 1'b0, 2, 1'b0);

        run_txn(4'b0101, 3, 1'b0, 2, 1'b0);
        run_txn(4'b0101, 3, 1'b1, 2, 1'b0);

        // Request withdrawn while the arbiter is deciding.
        req = 4'b0100;
        @(negedge ACLK);
        chk("arb_busy", busy, 1);
        req = '0;
        @(negedge ACLK);
        chk("arb_drop_busy", busy, 0);
        chk("arb_drop_gnt", gnt, 0);
        chk("arb_drop_init", txn_init, 0);

        for (int t = 0; t < 24; t++) begin
            run_txn(NR'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 2, 1'b0);
        end

        // Leave the pointer at 2, then reset in the middle of WAIT.
        run_txn(4'b0010, 0, 1'b0, 2, 1'b0);
        txn_done = 1'b0;
        req      = 4'b0110;
        got      = 1'b0;
        for (int n = 1; n <= 12 && !got; n++) begin
            @(negedge ACLK);
            if (txn_init) got = 1'b1;
        end
        chk("pre_rst_init", got, 1);
        repeat (5) @(negedge ACLK);
        chk("pre_rst_busy", busy, 1);
        ARESETN = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge ACLK);
            chk("mid_rst_gnt", gnt, 0);
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_ack", ack, 0);
            chk("mid_rst_init", txn_init, 0);
            chk("mid_rst_errc", err_count, 0);
        end
        ARESETN = 1'b1;
        m_ptr = 0;
        m_err = 0;
        run_txn(4'b0110, 0, 1'b0, 4, 1'b0);
        run_txn(4'b0110, 0, 1'b1, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
